// File: rtl/cmd_queue_loader_pkg.sv
// Shared types for the command queue loader.
// Command layout, memory word width and loader FSM states.
package cmd_queue_loader_pkg;

  localparam int CMD_LOADER_WORD_W = 32;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] arg;
    logic [31:0] payload;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } loader_state_t;

endpackage

// File: rtl/cmd_queue_loader_if.sv
// Memory-read and queue-write bus of the loader.
// master = loader side, slave = memory/FIFO side.
interface cmd_queue_loader_if
  import cmd_queue_loader_pkg::*;
#(
  parameter int CMD_W  = $bits(cmd_t),
  parameter int WORD_W = CMD_LOADER_WORD_W,
  parameter int ADDR_W = 18
);
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] i_mem_data;
  logic              o_queue_write;
  logic [CMD_W-1:0]  o_queue_data;
  logic              i_queue_full;

  modport master (
    output o_mem_rd, o_mem_addr,
    output o_queue_write, o_queue_data,
    input  i_mem_data, i_queue_full
  );

  modport slave (
    input  o_mem_rd, o_mem_addr,
    input  o_queue_write, o_queue_data,
    output i_mem_data, i_queue_full
  );
endinterface

// File: rtl/cmd_queue_loader_skid.sv
// cmd_skid_buf: 2-entry output FIFO of assembled commands.
// The parent's credit check guarantees no push into a full buffer.
module cmd_skid_buf #(
  parameter int CMD_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_head,
  output logic [1:0]       o_count
);
  logic [CMD_W-1:0] mem_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       cnt_q, cnt_d;

  assign cnt_d   = cnt_q + {1'b0, i_push} - {1'b0, i_pop};
  assign o_head  = mem_q[rp_q];
  assign o_count = cnt_q;

  // storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (i_push) begin
        mem_q[wp_q] <= i_data;
        wp_q        <= ~wp_q;
      end
      if (i_pop) rp_q <= ~rp_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cmd_queue_loader.sv
// Walks a command image in word memory and fills the command FIFO.
// Beat 0 of each command lands in the MSBs; reads are credit-limited.
module cmd_queue_loader
  import cmd_queue_loader_pkg::*;
#(
  parameter int CMD_W  = $bits(cmd_t),
  parameter int WORD_W = CMD_LOADER_WORD_W,
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 18
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_cmds,
  output logic              o_busy,
  output logic              o_done,
  cmd_queue_loader_if.master bus
);
  localparam int BEATS = CMD_W / WORD_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (CMD_W % WORD_W != 0) begin : g_bad_width
    $error("CMD_W must be a multiple of WORD_W");
  end

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cmds_q, cmds_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              rd_vld_q, rd_last_q;
  logic [CMD_W-1:0]  asm_d;
  logic [1:0]        cnt;
  logic [2:0]        occ;
  logic              last_beat, issue, push, pop;

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign push      = rd_vld_q && rd_last_q;
  assign pop       = (cnt != 2'd0) && !bus.i_queue_full;
  // occupancy the buffer will have after this edge
  assign occ       = {1'b0, cnt} + {2'b0, push} - {2'b0, pop};
  assign issue     = (state_q == FETCH) && (!last_beat || occ < 3'd2);

  assign bus.o_mem_rd      = issue;
  assign bus.o_mem_addr    = addr_q;
  assign bus.o_queue_write = pop;
  assign o_busy            = (state_q == FETCH) || (state_q == DRAIN);
  assign o_done            = (state_q == DONE);

  // next-state, address walk and command countdown
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmds_d  = cmds_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = i_base_addr;
          cmds_d  = i_num_cmds;
          beat_d  = '0;
          state_d = (i_num_cmds == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          beat_d = last_beat ? '0 : beat_q + BW'(1);
          if (last_beat) begin
            cmds_d = cmds_q - CNT_W'(1);
            if (cmds_q == CNT_W'(1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!rd_vld_q && occ == 3'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and read-pipeline registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cmds_q    <= '0;
      beat_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmds_q    <= cmds_d;
      beat_q    <= beat_d;
      rd_vld_q  <= issue;
      rd_last_q <= issue && last_beat;
    end
  end

  if (BEATS > 1) begin : g_shift
    logic [CMD_W-1:0] asm_q;
    assign asm_d = {asm_q[CMD_W-WORD_W-1:0], bus.i_mem_data};
    // shift returning beats in from the LSB end
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) asm_q <= '0;
      else if (rd_vld_q) asm_q <= asm_d;
    end
  end else begin : g_word
    assign asm_d = bus.i_mem_data;
  end

  cmd_skid_buf #(.CMD_W(CMD_W)) u_buf (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (push),
    .i_data (asm_d),
    .i_pop  (pop),
    .o_head (bus.o_queue_data),
    .o_count(cnt)
  );
endmodule

// File: tb/tb_cmd_queue_loader.sv
// Directed bench: u2 has 2 beats/command, u1 has 1 beat/command.
// Memory word at address a is {~a[13:0], a}.
module tb_cmd_queue_loader;
  logic clk, rstn;
  logic st2, st1, busy2, busy1, done2, done1;
  logic [17:0] base2, base1, num2, num1;
  int cyc, pass_cnt, tot_cnt;

  cmd_queue_loader_if #(.CMD_W(64)) b2 ();
  cmd_queue_loader_if #(.CMD_W(32)) b1 ();

  cmd_queue_loader #(.CMD_W(64)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_start(st2),
    .i_base_addr(base2), .i_num_cmds(num2),
    .o_busy(busy2), .o_done(done2), .bus(b2));
  cmd_queue_loader #(.CMD_W(32)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_start(st1),
    .i_base_addr(base1), .i_num_cmds(num1),
    .o_busy(busy1), .o_done(done1), .bus(b1));

  function automatic logic [31:0] pat(input logic [17:0] a);
    return {~a[13:0], a};
  endfunction

  function automatic logic [63:0] cmd2(input logic [17:0] a);
    logic [17:0] n;
    n = a + 18'd1;
    return {pat(a), pat(n)};
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (b2.o_mem_rd) b2.i_mem_data <= pat(b2.o_mem_addr);
  always @(posedge clk) if (b1.o_mem_rd) b1.i_mem_data <= pat(b1.o_mem_addr);

  logic [17:0] rd2[$], rd1[$];
  logic [63:0] wr2[$];
  logic [31:0] wr1[$];
  int rdc2[$], wrc2[$], dn2[$], rdc1[$], wrc1[$], dn1[$];
  logic busy_prev2, busy_at2, busy_pre2;
  int rd_tot1, rd_lag1, wr_tot1, occ_max1, wr_full1;

  always @(negedge clk) begin
    if (b2.o_mem_rd) begin rd2.push_back(b2.o_mem_addr); rdc2.push_back(cyc); end
    if (b2.o_queue_write) begin wr2.push_back(b2.o_queue_data); wrc2.push_back(cyc); end
    if (done2) begin dn2.push_back(cyc); busy_at2 = busy2; busy_pre2 = busy_prev2; end
    busy_prev2 = busy2;
    if (rd_lag1 - wr_tot1 > occ_max1) occ_max1 = rd_lag1 - wr_tot1;
    rd_lag1 = rd_tot1;
    if (b1.o_mem_rd) begin rd1.push_back(b1.o_mem_addr); rdc1.push_back(cyc); rd_tot1++; end
    if (b1.o_queue_write) begin
      wr1.push_back(b1.o_queue_data); wrc1.push_back(cyc); wr_tot1++;
      if (b1.i_queue_full) wr_full1++;
    end
    if (done1) dn1.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear2();
    rd2.delete(); wr2.delete(); rdc2.delete(); wrc2.delete(); dn2.delete();
  endtask

  task automatic start2(input logic [17:0] b, input logic [17:0] n);
    st2 = 1; base2 = b; num2 = n;
    step();
    st2 = 0;
  endtask

  task automatic wait_done2(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (dn2.size() > 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    step(); step();
    tot_cnt++;
    if ({b2.o_mem_rd, b2.o_queue_write, busy2, done2} !== 4'b0)
      $display("FAIL reset_ctl2: got %b want 0000",
               {b2.o_mem_rd, b2.o_queue_write, busy2, done2});
    else pass_cnt++;
    tot_cnt++;
    if (b2.o_mem_addr !== 18'h0) $display("FAIL reset_addr2: got %h want 0", b2.o_mem_addr);
    else pass_cnt++;
    tot_cnt++;
    if (b2.o_queue_data !== 64'h0) $display("FAIL reset_data2: got %h want 0", b2.o_queue_data);
    else pass_cnt++;
    tot_cnt++;
    if ({b1.o_mem_rd, b1.o_queue_write, busy1, done1} !== 4'b0)
      $display("FAIL reset_ctl1: got %b want 0000",
               {b1.o_mem_rd, b1.o_queue_write, busy1, done1});
    else pass_cnt++;
    rstn = 1;
    step();
  endtask

  task automatic test_basic();
    int s; bit ok;
    clear2();
    s = cyc;
    start2(18'h100, 18'd3);
    wait_done2(40, ok);
    tot_cnt++;
    if (!ok) $display("FAIL basic_done_timeout: got none want pulse"); else pass_cnt++;
    tot_cnt++;
    if (rd2.size() != 6) $display("FAIL basic_nreads: got %0d want 6", rd2.size());
    else pass_cnt++;
    for (int i = 0; i < rd2.size() && i < 6; i++) begin
      tot_cnt++;
      if (rd2[i] !== 18'h100 + 18'(i))
        $display("FAIL basic_addr%0d: got %h want %h", i, rd2[i], 18'h100 + 18'(i));
      else pass_cnt++;
    end
    if (rdc2.size() == 6) begin
      tot_cnt++;
      if (rdc2[0] != s + 1) $display("FAIL basic_first_rd: got %0d want %0d", rdc2[0], s + 1);
      else pass_cnt++;
      tot_cnt++;
      if (rdc2[5] - rdc2[0] != 5) $display("FAIL basic_rd_span: got %0d want 5", rdc2[5] - rdc2[0]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (wr2.size() != 3) $display("FAIL basic_nwrites: got %0d want 3", wr2.size());
    else pass_cnt++;
    for (int i = 0; i < wr2.size() && i < 3; i++) begin
      tot_cnt++;
      if (wr2[i] !== cmd2(18'h100 + 18'(2 * i)))
        $display("FAIL basic_cmd%0d: got %h want %h", i, wr2[i], cmd2(18'h100 + 18'(2 * i)));
      else pass_cnt++;
    end
    if (ok && wrc2.size() == 3) begin
      tot_cnt++;
      if (dn2[0] != wrc2[2] + 1) $display("FAIL basic_done_cyc: got %0d want %0d", dn2[0], wrc2[2] + 1);
      else pass_cnt++;
    end
    tot_cnt++;
    if ({busy_pre2, busy_at2} !== 2'b10)
      $display("FAIL basic_busy_edge: got %b want 10", {busy_pre2, busy_at2});
    else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int s;
    clear2();
    s = cyc;
    start2(18'h010, 18'd0);
    step(); step(); step();
    tot_cnt++;
    if (rd2.size() + wr2.size() != 0)
      $display("FAIL zero_traffic: got %0d want 0", rd2.size() + wr2.size());
    else pass_cnt++;
    tot_cnt++;
    if (dn2.size() != 1 || dn2[0] != s + 1)
      $display("FAIL zero_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dn2.size(), dn2[0], s + 1);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int s, exp_rd[8], k;
    exp_rd = '{1, 2, 13, 14, 15, 16, 17, 18};
    s = cyc;
    st1 = 1; base1 = 18'h040; num1 = 18'd8;
    step();
    st1 = 0;
    for (k = 1; k <= 60; k++) begin
      b1.i_queue_full = (k >= 3 && k <= 12);
      step();
      if (dn1.size() > 0) break;
    end
    b1.i_queue_full = 0;
    tot_cnt++;
    if (dn1.size() != 1 || dn1[0] != s + 21)
      $display("FAIL bp_done: got n=%0d cyc=%0d want n=1 cyc=%0d", dn1.size(), dn1[0] - s, 21);
    else pass_cnt++;
    tot_cnt++;
    if (rd1.size() != 8) $display("FAIL bp_nreads: got %0d want 8", rd1.size());
    else pass_cnt++;
    for (int i = 0; i < rdc1.size() && i < 8; i++) begin
      tot_cnt++;
      if (rdc1[i] - s != exp_rd[i])
        $display("FAIL bp_rd_cyc%0d: got %0d want %0d", i, rdc1[i] - s, exp_rd[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (wr1.size() != 8) $display("FAIL bp_nwrites: got %0d want 8", wr1.size());
    else pass_cnt++;
    for (int i = 0; i < wr1.size() && i < 8; i++) begin
      tot_cnt++;
      if (wr1[i] !== pat(18'h040 + 18'(i)) || wrc1[i] - s != 13 + i)
        $display("FAIL bp_wr%0d: got %h@%0d want %h@%0d", i, wr1[i], wrc1[i] - s,
                 pat(18'h040 + 18'(i)), 13 + i);
      else pass_cnt++;
    end
    tot_cnt++;
    if (occ_max1 != 2) $display("FAIL bp_max_occ: got %0d want 2", occ_max1);
    else pass_cnt++;
    tot_cnt++;
    if (wr_full1 != 0) $display("FAIL bp_write_while_full: got %0d want 0", wr_full1);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [17:0] ea[4];
    ea = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    clear2();
    start2(18'h3FFFE, 18'd2);
    wait_done2(30, ok);
    tot_cnt++;
    if (!ok || rd2.size() != 4) $display("FAIL wrap_nreads: got %0d want 4", rd2.size());
    else pass_cnt++;
    for (int i = 0; i < rd2.size() && i < 4; i++) begin
      tot_cnt++;
      if (rd2[i] !== ea[i]) $display("FAIL wrap_addr%0d: got %h want %h", i, rd2[i], ea[i]);
      else pass_cnt++;
    end
    tot_cnt++;
    if (wr2.size() != 2 || wr2[0] !== cmd2(18'h3FFFE) || wr2[1] !== cmd2(18'h00000))
      $display("FAIL wrap_cmds: got n=%0d %h %h want %h %h", wr2.size(), wr2[0], wr2[1],
               cmd2(18'h3FFFE), cmd2(18'h00000));
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    clear2();
    start2(18'h200, 18'd4);
    for (int i = 0; i < 20 && rd2.size() < 5; i++) step();
    tot_cnt++;
    if (rd2.size() < 5) $display("FAIL mid_reads_reached: got %0d want 5", rd2.size());
    else pass_cnt++;
    rstn = 0;
    #1;
    tot_cnt++;
    if ({b2.o_mem_rd, b2.o_queue_write, busy2, done2} !== 4'b0 ||
        b2.o_mem_addr !== 18'h0 || b2.o_queue_data !== 64'h0)
      $display("FAIL mid_reset_outs: got %b %h %h want 0000 0 0",
               {b2.o_mem_rd, b2.o_queue_write, busy2, done2}, b2.o_mem_addr, b2.o_queue_data);
    else pass_cnt++;
    step(); step();
    rstn = 1;
    step();
    clear2();
    start2(18'h300, 18'd2);
    wait_done2(30, ok);
    tot_cnt++;
    if (!ok || wr2.size() != 2 || wr2[0] !== cmd2(18'h300) || wr2[1] !== cmd2(18'h302))
      $display("FAIL mid_restart: got n=%0d %h %h want %h %h", wr2.size(), wr2[0], wr2[1],
               cmd2(18'h300), cmd2(18'h302));
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear2();
    start2(18'h400, 18'd3);
    step(); step();
    start2(18'h500, 18'd5);
    wait_done2(40, ok);
    step(); step(); step();
    tot_cnt++;
    if (!ok || wr2.size() != 3 || rd2.size() != 6)
      $display("FAIL busy_counts: got w=%0d r=%0d want w=3 r=6", wr2.size(), rd2.size());
    else pass_cnt++;
    for (int i = 0; i < wr2.size() && i < 3; i++) begin
      tot_cnt++;
      if (wr2[i] !== cmd2(18'h400 + 18'(2 * i)))
        $display("FAIL busy_cmd%0d: got %h want %h", i, wr2[i], cmd2(18'h400 + 18'(2 * i)));
      else pass_cnt++;
    end
  endtask

  initial begin
    rstn = 0; st2 = 0; st1 = 0;
    base2 = '0; base1 = '0; num2 = '0; num1 = '0;
    b2.i_queue_full = 0; b1.i_queue_full = 0;
    pass_cnt = 0; tot_cnt = 0;
    rd_tot1 = 0; rd_lag1 = 0; wr_tot1 = 0; occ_max1 = 0; wr_full1 = 0;
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_wrap();
    test_reset_midrun();
    test_start_while_busy();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
